sync_fifo_flex: RTL

Parametrised single-clock FIFO, the successor to the basic `fifo` buffer used between streaming blocks. It adds a selectable read mode (registered or first-word-fall-through), programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. Write-while-full is accepted when a read occurs in the same cycle.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/sync_fifo_flex_if.sv | 32 +++
 rtl/fifo_ram.sv | 40 ++++
 rtl/sync_fifo_flex.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants, read-mode enum and helpers for the sync_fifo_flex family.
package fifo_pkg;

  localparam int unsigned AWIDTH_DEF = 8;
  localparam int unsigned DWIDTH_DEF = 5;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Smallest n such that 2**n >= value.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Write/read handshake and status bundle between a producer/consumer and sync_fifo_flex.
interface sync_fifo_flex_if
  import fifo_pkg::*;
#(
  parameter int unsigned AWIDTH = AWIDTH_DEF,
  parameter int unsigned DWIDTH = DWIDTH_DEF
);

  logic [DWIDTH-1:0] data_in;
  logic              wr_en;
  logic              rd_en;
  logic              clr_err;
  logic [DWIDTH-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [AWIDTH:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output data_in, wr_en, rd_en, clr_err,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  data_in, wr_en, rd_en, clr_err,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// Dual-port storage: synchronous write, read port either registered or combinational.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned  DEPTH  = 32'd1 << AWIDTH_DEF,
  parameter int unsigned  DWIDTH = DWIDTH_DEF,
  parameter bit           REG_RD = 1'b1,
  localparam int unsigned AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DWIDTH-1:0] o_rdata
);

  logic [DWIDTH-1:0] r_mem [DEPTH];

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  if (REG_RD) begin : g_reg_rd
    logic [DWIDTH-1:0] r_rdata;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)      r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
  end else begin : g_comb_rd
    assign o_rdata = r_mem[i_raddr];
  end

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with registered or fall-through read, threshold flags,
// occupancy count and sticky overflow/underflow flags.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int unsigned AWIDTH   = AWIDTH_DEF,
  parameter int unsigned DWIDTH   = DWIDTH_DEF,
  parameter int unsigned FWFT     = 0,
  parameter int unsigned AF_LEVEL = (32'd1 << AWIDTH) - 32'd2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic            clk,
  input  logic            rst,
  sync_fifo_flex_if.slave bus
);

  localparam int unsigned   DEPTH    = 32'd1 << AWIDTH;
  localparam int unsigned   PW       = AWIDTH + 1;
  localparam fifo_mode_e    MODE     = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
  localparam logic [PW-1:0] AF_CNT   = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_CNT   = PW'(AE_LEVEL);

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_flex: AF_LEVEL %0d outside 1..%0d", AF_LEVEL, DEPTH);
  end
  if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_flex: AE_LEVEL %0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
  end
  if (FWFT > 1) begin : g_bad_fwft
    $error("sync_fifo_flex: FWFT must be 0 or 1, got %0d", FWFT);
  end

  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_af;
  logic              r_ae;
  logic              r_ovf;
  logic              r_udf;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [PW-1:0]     w_wr_ptr_nxt;
  logic [PW-1:0]     w_rd_ptr_nxt;
  logic [PW-1:0]     w_count_nxt;
  logic              w_ovf_set;
  logic              w_udf_set;
  logic [AWIDTH-1:0] w_raddr;
  logic              w_ram_re;
  logic [DWIDTH-1:0] w_rdata;

  // A write into a full FIFO is still accepted when the same cycle pops a word.
  always_comb begin
    w_wr_acc     = bus.wr_en & (~r_full | bus.rd_en);
    w_rd_acc     = bus.rd_en & ~r_empty;
    w_wr_ptr_nxt = r_wr_ptr + PW'(w_wr_acc);
    w_rd_ptr_nxt = r_rd_ptr + PW'(w_rd_acc);
    w_count_nxt  = r_count;
    if (w_wr_acc && !w_rd_acc)      w_count_nxt = r_count + PW'(1);
    else if (!w_wr_acc && w_rd_acc) w_count_nxt = r_count - PW'(1);
    w_ovf_set    = bus.wr_en & r_full & ~bus.rd_en;
    w_udf_set    = bus.rd_en & r_empty;
  end

  // Status flags are decoded from the next count so they are registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == FULL_CNT);
      r_empty  <= (w_count_nxt == '0);
      r_af     <= (w_count_nxt >= AF_CNT);
      r_ae     <= (w_count_nxt <= AE_CNT);
      r_ovf    <= w_ovf_set | (r_ovf & ~bus.clr_err);
      r_udf    <= w_udf_set | (r_udf & ~bus.clr_err);
    end
  end

  if (MODE == FIFO_STD) begin : g_std
    assign w_raddr      = r_rd_ptr[AWIDTH-1:0];
    assign w_ram_re     = w_rd_acc;
    assign bus.data_out = w_rdata;
  end else begin : g_fwft
    logic [DWIDTH-1:0] r_head;
    logic [DWIDTH-1:0] w_head_nxt;

    assign w_raddr  = w_rd_ptr_nxt[AWIDTH-1:0];
    assign w_ram_re = 1'b0;

    // Next head word; bypass the write data when it lands at the head slot.
    always_comb begin
      w_head_nxt = w_rdata;
      if (w_count_nxt == '0) begin
        w_head_nxt = '0;
      end else if (w_wr_acc && (r_wr_ptr[AWIDTH-1:0] == w_raddr)) begin
        w_head_nxt = bus.data_in;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_head <= '0;
      else      r_head <= w_head_nxt;
    end

    assign bus.data_out = r_head;
  end

  fifo_ram #(
    .DEPTH  (DEPTH),
    .DWIDTH (DWIDTH),
    .REG_RD (MODE == FIFO_STD)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[AWIDTH-1:0]),
    .i_wdata (bus.data_in),
    .i_re    (w_ram_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_af;
  assign bus.almost_empty = r_ae;
  assign bus.count        = r_count;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_udf;

endmodule
